// File: rtl/light_uart_rx_core_if.sv
// Read-side handshake of the light UART receiver FIFO.
// The receiver drives data/valid and the consumer drives ready.
interface light_uart_rx_core_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    modport master (
        output rd_data,
        output rd_valid,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        output rd_ready
    );
endinterface

// File: rtl/light_uart_rx_core.sv
// Light UART receiver: rxd synchroniser, mid-bit sampling frame FSM and a
// first-word-fall-through byte FIFO with rts flow control.
module light_uart_rx_core #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned RTS_MARGIN  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   dbr,
    input  logic                          rxd,
    output logic                          rts,
    light_uart_rx_core_if.master          rd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] RTS_LEVEL  = (AW + 1)'(FIFO_DEPTH - RTS_MARGIN);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // rxd synchroniser, preset to the idle level
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [19:0] timer_q, timer_d;
    logic [19:0] cpb_q, cpb_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] dbr_eff;
    logic [19:0] cpb_new;
    logic        timer_zero;
    logic        push_req;
    logic        ferr_set;

    assign dbr_eff    = (dbr == '0) ? 16'd1 : dbr;
    assign cpb_new    = {dbr_eff, 4'b0000};
    assign timer_zero = (timer_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            cpb_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cpb_q   <= cpb_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_zero ? timer_q : timer_q - 20'd1;
        cpb_d    = cpb_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        ferr_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    // divisor is captured here so a mid-frame dbr change waits a frame
                    state_d = START;
                    cpb_d   = cpb_new;
                    timer_d = (cpb_new >> 1) - 20'd1;
                end
            end
            START: begin
                if (timer_zero) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                        timer_d = cpb_q - 20'd1;
                    end
                end
            end
            DATA: begin
                if (timer_zero) begin
                    shift_d[idx_q] = rxs;
                    timer_d        = cpb_q - 20'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // leaving at mid stop bit re-arms before a back-to-back start edge
                if (timer_zero) begin
                    if (rxs) begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = BREAK_WAIT;
                    end
                end
            end
            BREAK_WAIT: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q, count_next;
    logic          full;
    logic          pop;
    logic          push;
    logic          ovr_set;

    assign full    = (count_q == FULL_LEVEL);
    assign pop     = rd.rd_valid && rd.rd_ready;
    assign push    = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;

    always_comb begin
        count_next = count_q;
        unique case ({push, pop})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            rts       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q   <= count_next;
            rts       <= (count_next >= RTS_LEVEL);
            frame_err <= ferr_set;
            overrun   <= ovr_set;
        end
    end

    assign fifo_count  = count_q;
    assign rd.rd_valid = (count_q != '0);
    assign rd.rd_data  = rd.rd_valid ? mem[rd_ptr] : '0;

endmodule
